// File: rtl/stim_step_sequencer_pkg.sv
// Shared types and default widths for the timed stimulus sequencer.
package fsm_tb_pkg;

    localparam int DEF_NUM_STEPS = 13;
    localparam int DEF_DUR_W     = 16;
    localparam int DEF_VEC_W     = 4;
    localparam int DEF_IDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    typedef struct packed {
        logic [DEF_DUR_W-1:0] dur;
        logic [DEF_VEC_W-1:0] vec;
        logic                 exp;
    } step_entry_t;

endpackage

// File: rtl/stim_step_sequencer_if.sv
// Control/config and DUT-facing signals of the stimulus sequencer.
interface stim_step_sequencer_if
    import fsm_tb_pkg::*;
#(
    parameter int DUR_W = DEF_DUR_W,
    parameter int VEC_W = DEF_VEC_W,
    parameter int IDX_W = DEF_IDX_W
) ();

    logic             cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    logic [DUR_W-1:0] cfg_dur;
    logic [VEC_W-1:0] cfg_vec;
    logic             cfg_exp;
    logic [IDX_W-1:0] cfg_last;
    logic             start;
    logic             abort;
    logic             dut_out;
    logic [VEC_W-1:0] stim_vec;
    logic [IDX_W-1:0] step_idx;
    logic             busy;
    logic             done;
    logic [IDX_W:0]   err_cnt;

    modport master (
        output cfg_we, cfg_addr, cfg_dur, cfg_vec, cfg_exp, cfg_last,
        output start, abort, dut_out,
        input  stim_vec, step_idx, busy, done, err_cnt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_dur, cfg_vec, cfg_exp, cfg_last,
        input  start, abort, dut_out,
        output stim_vec, step_idx, busy, done, err_cnt
    );

endinterface

// File: rtl/stim_step_sequencer_table.sv
// Step table register file: one write port, one combinational read port, no reset.
module stim_step_table #(
    parameter int NUM_STEPS = 13,
    parameter int IDX_W     = 4,
    parameter int ENTRY_W   = 21
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [IDX_W-1:0]   raddr,
    output logic [ENTRY_W-1:0] rdata
);

    localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(NUM_STEPS);

    logic [ENTRY_W-1:0] mem [NUM_STEPS];

    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/stim_step_sequencer.sv
// Steps through the programmed table, driving each vector for its duration and
// scoring the DUT output on the last cycle of every step.
module stim_step_sequencer
    import fsm_tb_pkg::*;
#(
    parameter int NUM_STEPS = DEF_NUM_STEPS,
    parameter int DUR_W     = DEF_DUR_W,
    parameter int VEC_W     = DEF_VEC_W,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    stim_step_sequencer_if.slave  bus
);

    localparam int               ENTRY_W  = DUR_W + VEC_W + 1;
    localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(NUM_STEPS - 1);

    state_t             state;
    logic [DUR_W-1:0]   cnt;
    logic [IDX_W-1:0]   last_reg;
    logic               cur_exp;
    logic [VEC_W-1:0]   stim_vec_r;
    logic [IDX_W-1:0]   step_idx_r;
    logic               busy_r;
    logic               done_r;
    logic [IDX_W:0]     err_cnt_r;

    logic [IDX_W-1:0]   rd_addr;
    logic [ENTRY_W-1:0] rd_data;
    logic [ENTRY_W-1:0] nxt_entry;
    logic [DUR_W-1:0]   nxt_dur;
    logic [VEC_W-1:0]   nxt_vec;
    logic               nxt_exp;
    logic               step_end;

    stim_step_table #(
        .NUM_STEPS (NUM_STEPS),
        .IDX_W     (IDX_W),
        .ENTRY_W   (ENTRY_W)
    ) u_table (
        .clk   (clk),
        .we    (bus.cfg_we && (state == IDLE)),
        .waddr (bus.cfg_addr),
        .wdata ({bus.cfg_dur, bus.cfg_vec, bus.cfg_exp}),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // The single read port looks one step ahead while running and at entry 0
    // in IDLE; a same-cycle write to entry 0 is forwarded so start sees it.
    always_comb begin
        rd_addr   = (state == RUN) ? step_idx_r + 1'b1 : '0;
        nxt_entry = rd_data;
        if ((state == IDLE) && bus.cfg_we && (bus.cfg_addr == '0)) begin
            nxt_entry = {bus.cfg_dur, bus.cfg_vec, bus.cfg_exp};
        end
        {nxt_dur, nxt_vec, nxt_exp} = nxt_entry;
        if (nxt_dur == '0) begin
            nxt_dur = DUR_W'(1);
        end
    end

    assign step_end = (cnt <= DUR_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            stim_vec_r <= '0;
            step_idx_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_cnt_r  <= '0;
            cnt        <= '0;
            last_reg   <= '0;
            cur_exp    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        last_reg   <= (bus.cfg_last > LAST_MAX) ? LAST_MAX : bus.cfg_last;
                        step_idx_r <= '0;
                        err_cnt_r  <= '0;
                        cnt        <= nxt_dur;
                        stim_vec_r <= nxt_vec;
                        cur_exp    <= nxt_exp;
                        busy_r     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        stim_vec_r <= '0;
                        busy_r     <= 1'b0;
                        state      <= IDLE;
                    end else if (step_end) begin
                        if ((bus.dut_out != cur_exp) && (err_cnt_r != '1)) begin
                            err_cnt_r <= err_cnt_r + 1'b1;
                        end
                        if (step_idx_r == last_reg) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= FINISH;
                        end else begin
                            step_idx_r <= step_idx_r + 1'b1;
                            cnt        <= nxt_dur;
                            stim_vec_r <= nxt_vec;
                            cur_exp    <= nxt_exp;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FINISH: begin
                    done_r <= 1'b0;
                    if (bus.abort) begin
                        stim_vec_r <= '0;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.stim_vec = stim_vec_r;
    assign bus.step_idx = step_idx_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_stim_step_sequencer.sv
// Directed bench: stimulus pushes expected step segments and done records,
// a negedge monitor pops and compares them as the sequencer presents them.
module tb_stim_step_sequencer;
    import fsm_tb_pkg::*;

    localparam int NUM_STEPS = 13;
    localparam int DUR_W     = 16;
    localparam int VEC_W     = 4;
    localparam int IDX_W     = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stim_step_sequencer_if #(.DUR_W(DUR_W), .VEC_W(VEC_W), .IDX_W(IDX_W)) bus ();

    stim_step_sequencer #(
        .NUM_STEPS (NUM_STEPS),
        .DUR_W     (DUR_W),
        .VEC_W     (VEC_W),
        .IDX_W     (IDX_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit is_done;
        int idx;
        int vec;
        int val;
    } exp_t;
    exp_t sb[$];

    function automatic int enc(input bit d, input int idx, input int vec, input int val);
        return (int'(d) << 24) | (idx << 16) | (vec << 8) | val;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_seg(input int idx, input int vec, input int len);
        exp_t e;
        e.is_done = 1'b0; e.idx = idx; e.vec = vec; e.val = len;
        sb.push_back(e);
    endtask

    task automatic push_done(input int idx, input int vec, input int err);
        exp_t e;
        e.is_done = 1'b1; e.idx = idx; e.vec = vec; e.val = err;
        sb.push_back(e);
    endtask

    task automatic mon_pop(input string name, input int act);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: unexpected record 0x%0h, nothing expected", name, act);
        end else begin
            e = sb.pop_front();
            check(name, act, enc(e.is_done, e.idx, e.vec, e.val));
        end
    endtask

    // Monitor: a segment is a contiguous busy run at one step index.
    initial begin : monitor
        bit seg_open;
        int seg_idx, seg_vec, seg_len;
        seg_open = 1'b0;
        seg_idx = 0; seg_vec = 0; seg_len = 0;
        forever begin
            @(negedge clk);
            if (seg_open && (!bus.busy || int'(bus.step_idx) != seg_idx)) begin
                seg_open = 1'b0;
                mon_pop("seg", enc(1'b0, seg_idx, seg_vec, seg_len));
            end
            if (bus.busy) begin
                if (!seg_open) begin
                    seg_open = 1'b1;
                    seg_idx  = int'(bus.step_idx);
                    seg_vec  = int'(bus.stim_vec);
                    seg_len  = 1;
                end else begin
                    seg_len++;
                    if (int'(bus.stim_vec) != seg_vec) seg_vec = 'hFF;
                end
            end
            if (bus.done) begin
                mon_pop("done", enc(1'b1, int'(bus.step_idx), int'(bus.stim_vec), int'(bus.err_cnt)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d, input int v, input bit e);
        step_entry_t ent;
        ent.dur = DUR_W'(d);
        ent.vec = VEC_W'(v);
        ent.exp = e;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = IDX_W'(a);
        bus.cfg_dur  = ent.dur;
        bus.cfg_vec  = ent.vec;
        bus.cfg_exp  = ent.exp;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic go(input int last);
        bus.cfg_last = IDX_W'(last);
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (bus.done) begin
                cyc = k;
                break;
            end
        end
        if (cyc == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: no done within %0d cycles", budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stim_vec"}, int'(bus.stim_vec), 0);
        check({tag, "_step_idx"}, int'(bus.step_idx), 0);
        check({tag, "_busy"},     int'(bus.busy),     0);
        check({tag, "_done"},     int'(bus.done),     0);
        check({tag, "_err_cnt"},  int'(bus.err_cnt),  0);
    endtask

    task automatic push_t4_run();
        for (int i = 0; i < NUM_STEPS; i++) begin
            push_seg(i, i, ((i % 3) == 0) ? 1 : (i % 3));
        end
        push_done(12, 12, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int  c;
        bit  found;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_dur = '0; bus.cfg_vec = '0;
        bus.cfg_exp = 1'b0; bus.cfg_last = '0; bus.start = 1'b0; bus.abort = 1'b0;
        bus.dut_out = 1'b0;

        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst0");
        tick();

        // Basic three-step run: 2/5/1 cycles, done on cycle 9 after start.
        wr(0, 2, 1, 1'b0);
        wr(1, 5, 3, 1'b0);
        wr(2, 1, 15, 1'b0);
        push_seg(0, 1, 2);
        push_seg(1, 3, 5);
        push_seg(2, 15, 1);
        push_done(2, 15, 0);
        go(2);
        wait_done(40, c);
        check("t2_done_cycle", c, 9);
        @(negedge clk);
        check("t2_done_width", int'(bus.done), 0);
        tick();

        // Mismatches on steps 1 and 3; a new start clears the count.
        wr(0, 1, 2, 1'b0);
        wr(1, 2, 4, 1'b1);
        wr(2, 3, 6, 1'b0);
        wr(3, 1, 8, 1'b1);
        push_seg(0, 2, 1);
        push_seg(1, 4, 2);
        push_seg(2, 6, 3);
        push_seg(3, 8, 1);
        push_done(3, 8, 2);
        go(3);
        wait_done(40, c);
        tick();
        tick();
        check("t3_err_hold", int'(bus.err_cnt), 2);
        push_seg(0, 2, 1);
        push_done(0, 2, 0);
        go(0);
        @(negedge clk);
        check("t3_err_clear", int'(bus.err_cnt), 0);
        wait_done(20, c);
        tick();

        // Zero durations and cfg_last beyond the table clamp to the last entry.
        for (int i = 0; i < NUM_STEPS; i++) wr(i, i % 3, i, 1'b0);
        wr(13, 9, 9, 1'b1);
        push_t4_run();
        go(15);
        wait_done(100, c);
        tick();

        // Abort coincides with final-step completion: no done, err_cnt kept.
        bus.dut_out = 1'b1;
        push_seg(0, 0, 1);
        push_seg(1, 1, 1);
        go(1);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        check("t5_stim_vec", int'(bus.stim_vec), 0);
        check("t5_busy",     int'(bus.busy),     0);
        check("t5_done",     int'(bus.done),     0);
        check("t5_err_cnt",  int'(bus.err_cnt),  1);
        @(negedge clk);
        check("t5_no_late_done", int'(bus.done), 0);
        bus.dut_out = 1'b0;
        tick();

        // Writes and start during RUN are ignored.
        push_t4_run();
        go(12);
        tick();
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'd5; bus.cfg_dur = 16'd7;
        bus.cfg_vec = 4'hF; bus.cfg_exp = 1'b1; bus.cfg_last = '0; bus.start = 1'b1;
        tick();
        bus.cfg_we = 1'b0;
        bus.start  = 1'b0;
        wait_done(100, c);
        tick();

        // Write to entry 0 in the same cycle as start uses the new entry.
        bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_dur = 16'd3;
        bus.cfg_vec = 4'hA; bus.cfg_exp = 1'b0;
        push_seg(0, 10, 3);
        push_done(0, 10, 0);
        go(0);
        bus.cfg_we = 1'b0;
        wait_done(20, c);
        tick();

        // Reset in the middle of step 5.
        bus.dut_out = 1'b1;
        push_seg(0, 10, 3);
        push_seg(1, 1, 1);
        push_seg(2, 2, 2);
        push_seg(3, 3, 1);
        push_seg(4, 4, 1);
        push_seg(5, 5, 1);
        go(12);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.busy && (int'(bus.step_idx) == 5)) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL t1_reach_step5: step 5 not reached within 40 cycles");
        end
        check("t1_err_before", int'(bus.err_cnt), 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("t1");
        bus.dut_out = 1'b0;
        tick();
        tick();

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
